// File: rtl/mul_issue.sv
// Operand FIFO and issue sequencer for a shift-and-add multiplier: queues operand
// pairs, starts one multiplication at a time and returns each product with its issue tag.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no operation in flight; start one when the FIFO holds a pair
// ISSUE | mul_in_valid high for this cycle with the head pair; pop it
// WAIT  | wait for the finish pulse, or give up after TIMEOUT cycles
module mul_issue #(
    parameter int WIDTH   = 2,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 2 * WIDTH + 4,
    localparam int AW     = $clog2(DEPTH),
    localparam int CW     = $clog2(TIMEOUT + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               op_valid,
    output logic               op_ready,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    output logic               mul_in_valid,
    output logic [WIDTH-1:0]   mul_a,
    output logic [WIDTH-1:0]   mul_b,
    input  logic [2*WIDTH-1:0] mul_o,
    input  logic               mul_out_valid,
    output logic               res_valid,
    output logic [2*WIDTH-1:0] res_data,
    output logic [AW-1:0]      res_tag,
    output logic [AW:0]        level,
    output logic               err_timeout,
    output logic               err_proto
);

    localparam logic [AW:0] LEVEL_MAX = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  mem_a [DEPTH];
    logic [WIDTH-1:0]  mem_b [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     issue_cnt;
    logic [AW-1:0]     cur_tag;
    logic [CW-1:0]     wait_cnt;
    logic              push;
    logic              pop;

    assign op_ready = (level < LEVEL_MAX);
    assign push     = op_valid && op_ready;
    assign pop      = (state == S_ISSUE);

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_a[wr_ptr] <= op_a;
            mem_b[wr_ptr] <= op_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + (AW + 1)'(1);
                2'b01:   level <= level - (AW + 1)'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            mul_in_valid <= 1'b0;
            mul_a        <= '0;
            mul_b        <= '0;
            res_valid    <= 1'b0;
            res_data     <= '0;
            res_tag      <= '0;
            issue_cnt    <= '0;
            cur_tag      <= '0;
            wait_cnt     <= '0;
            err_timeout  <= 1'b0;
            err_proto    <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (mul_out_valid) err_proto <= 1'b1;
                    // level is registered, so a pair pushed this cycle waits one more cycle
                    if (level != '0) begin
                        state        <= S_ISSUE;
                        mul_in_valid <= 1'b1;
                        mul_a        <= mem_a[rd_ptr];
                        mul_b        <= mem_b[rd_ptr];
                    end
                end
                S_ISSUE: begin
                    if (mul_out_valid) err_proto <= 1'b1;
                    mul_in_valid <= 1'b0;
                    cur_tag      <= issue_cnt;
                    issue_cnt    <= issue_cnt + AW'(1);
                    wait_cnt     <= CW'(TIMEOUT - 1);
                    state        <= S_WAIT;
                end
                S_WAIT: begin
                    // a finish on the last allowed cycle still wins over the timeout
                    if (mul_out_valid) begin
                        res_data  <= mul_o;
                        res_tag   <= cur_tag;
                        res_valid <= 1'b1;
                        state     <= S_IDLE;
                    end else if (wait_cnt == CW'(1)) begin
                        err_timeout <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt - CW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_issue.sv
// Directed bench for mul_issue: the bench plays the multiplier, feeding hand-computed
// products, and checks issue order, result tags, FIFO limits, error flags and reset.
module tb_mul_issue;

    localparam int WIDTH = 2;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       op_valid = 1'b0;
    logic       op_ready;
    logic [1:0] op_a = '0;
    logic [1:0] op_b = '0;
    logic       mul_in_valid;
    logic [1:0] mul_a;
    logic [1:0] mul_b;
    logic [3:0] mul_o = '0;
    logic       mul_out_valid = 1'b0;
    logic       res_valid;
    logic [3:0] res_data;
    logic [1:0] res_tag;
    logic [2:0] level;
    logic       err_timeout;
    logic       err_proto;

    int n_checks = 0;
    int n_pass   = 0;

    logic [3:0] iss_q [$];
    logic [5:0] res_q [$];

    always #5 clk = ~clk;

    mul_issue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .mul_in_valid(mul_in_valid), .mul_a(mul_a), .mul_b(mul_b),
        .mul_o(mul_o), .mul_out_valid(mul_out_valid),
        .res_valid(res_valid), .res_data(res_data), .res_tag(res_tag),
        .level(level), .err_timeout(err_timeout), .err_proto(err_proto)
    );

    always @(negedge clk) begin
        if (mul_in_valid) iss_q.push_back({mul_a, mul_b});
        if (res_valid)    res_q.push_back({res_tag, res_data});
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        iss_q.delete();
        res_q.delete();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic push(input logic [1:0] a, input logic [1:0] b);
        op_valid = 1'b1;
        op_a = a;
        op_b = b;
        step();
        op_valid = 1'b0;
    endtask

    task automatic finish(input logic [3:0] p);
        mul_out_valid = 1'b1;
        mul_o = p;
        step();
        mul_out_valid = 1'b0;
        mul_o = '0;
    endtask

    task automatic wait_issue(input string tag, input logic [1:0] a, input logic [1:0] b);
        int n = 0;
        logic [3:0] got;
        while (iss_q.size() == 0 && n < 20) begin
            step();
            n++;
        end
        chk({tag, " issued"}, iss_q.size() != 0, 1);
        got = (iss_q.size() != 0) ? iss_q.pop_front() : 4'hf;
        chk({tag, " a_b"}, got, {a, b});
    endtask

    task automatic wait_result(input string tag, input logic [3:0] d, input logic [1:0] t);
        int n = 0;
        logic [5:0] got;
        while (res_q.size() == 0 && n < 20) begin
            step();
            n++;
        end
        chk({tag, " result"}, res_q.size() != 0, 1);
        got = (res_q.size() != 0) ? res_q.pop_front() : 6'h3f;
        chk({tag, " data"}, got[3:0], d);
        chk({tag, " tag"}, got[5:4], t);
    endtask

    task automatic do_op(input string tag, input logic [1:0] a, input logic [1:0] b,
                         input logic [3:0] p, input logic [1:0] t);
        wait_issue(tag, a, b);
        step();
        chk({tag, " strobe_low"}, mul_in_valid, 0);
        chk({tag, " hold"}, {mul_a, mul_b}, {a, b});
        finish(p);
        wait_result(tag, p, t);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // reset values while rst is held
        rst = 1'b1;
        repeat (3) step();
        chk("rst level", level, 0);
        chk("rst res_valid", res_valid, 0);
        chk("rst res_data", res_data, 0);
        chk("rst res_tag", res_tag, 0);
        chk("rst mul_in_valid", mul_in_valid, 0);
        chk("rst mul_a_b", {mul_a, mul_b}, 0);
        chk("rst errs", {err_timeout, err_proto}, 0);
        iss_q.delete();
        res_q.delete();
        rst = 1'b0;
        step();
        chk("ready after rst", op_ready, 1);

        // single operation 3*2
        push(2'd3, 2'd2);
        do_op("op32", 2'd3, 2'd2, 4'd6, 2'd0);
        step();
        chk("op32 single result", res_q.size(), 0);

        // four queued pairs, tags count from zero
        do_reset();
        push(2'd3, 2'd3);
        push(2'd2, 2'd1);
        push(2'd0, 2'd3);
        push(2'd1, 2'd0);
        do_op("seq0", 2'd3, 2'd3, 4'd9, 2'd0);
        do_op("seq1", 2'd2, 2'd1, 4'd2, 2'd1);
        do_op("seq2", 2'd0, 2'd3, 4'd0, 2'd2);
        do_op("seq3", 2'd1, 2'd0, 4'd0, 2'd3);
        chk("seq errs", {err_timeout, err_proto}, 0);

        // fill FIFO while an operation is outstanding; the fifth pair is dropped
        do_reset();
        push(2'd1, 2'd1);
        wait_issue("full0", 2'd1, 2'd1);
        step();
        push(2'd2, 2'd1);
        push(2'd3, 2'd1);
        push(2'd1, 2'd2);
        push(2'd2, 2'd2);
        chk("full ready", op_ready, 0);
        chk("full level", level, 4);
        push(2'd3, 2'd3);
        chk("full level after 5th", level, 4);
        finish(4'd1);
        wait_result("full0", 4'd1, 2'd0);
        do_op("full1", 2'd2, 2'd1, 4'd2, 2'd1);
        do_op("full2", 2'd3, 2'd1, 4'd3, 2'd2);
        do_op("full3", 2'd1, 2'd2, 4'd2, 2'd3);
        do_op("full4", 2'd2, 2'd2, 4'd4, 2'd0);
        repeat (10) step();
        chk("full no 5th issue", iss_q.size(), 0);
        chk("full drained", level, 0);
        chk("full err_proto", err_proto, 0);

        // timeout: err_timeout rises 8 cycles after the ISSUE cycle
        do_reset();
        push(2'd1, 2'd3);
        push(2'd2, 2'd2);
        wait_issue("tmo0", 2'd1, 2'd3);
        for (int j = 1; j <= 8; j++) begin
            step();
            if (j == 7) chk("tmo not yet", err_timeout, 0);
        end
        chk("tmo set", err_timeout, 1);
        chk("tmo no result", res_q.size(), 0);
        do_op("tmo1", 2'd2, 2'd2, 4'd4, 2'd1);
        chk("tmo sticky", err_timeout, 1);

        // finish pulse while idle
        do_reset();
        step();
        finish(4'd5);
        chk("proto set", err_proto, 1);
        repeat (3) step();
        chk("proto no result", res_q.size(), 0);
        chk("proto no issue", iss_q.size(), 0);

        // reset in WAIT with two pairs queued
        do_reset();
        push(2'd1, 2'd1);
        push(2'd2, 2'd1);
        push(2'd3, 2'd1);
        chk("midrst level before", level, 2);
        chk("midrst issued", {mul_a, mul_b}, {2'd1, 2'd1});
        do_reset();
        chk("midrst level", level, 0);
        chk("midrst ready", op_ready, 1);
        chk("midrst res_valid", res_valid, 0);
        repeat (15) step();
        chk("midrst no issue", iss_q.size(), 0);
        chk("midrst no result", res_q.size(), 0);
        push(2'd2, 2'd3);
        do_op("midrst new", 2'd2, 2'd3, 4'd6, 2'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mul_issue.md
MUL_ISSUE -- requirements
Module: mul_issue

Interface
REQ-001 SHALL have parameter WIDTH, default 2, operand width in bits; results are 2*WIDTH bits.
REQ-002 SHALL have parameter DEPTH, default 4, operand FIFO entries (power of two).
REQ-003 SHALL have parameter TIMEOUT, default 2*WIDTH+4, maximum cycles from issue to mul_out_valid.
REQ-004 SHALL have one clock and a synchronous, active-high reset, with ports as follows:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- op_valid  in  1  operand pair offered.
- op_ready  out  1  FIFO can accept.
- op_a  in  WIDTH  multiplicand.
- op_b  in  WIDTH  multiplier.
- mul_in_valid  out  1  start strobe to the downstream shift-and-add multiplier.
- mul_a  out  WIDTH  multiplicand to the multiplier.
- mul_b  out  WIDTH  multiplier operand to the multiplier.
- mul_o  in  2*WIDTH  product from the multiplier.
- mul_out_valid  in  1  multiplier finish pulse.
- res_valid  out  1  one-cycle result strobe.
- res_data  out  2*WIDTH  captured product.
- res_tag  out  log2(DEPTH)  issue sequence number of the result.
- level  out  log2(DEPTH)+1  FIFO occupancy.
- err_timeout  out  1  sticky; no finish within TIMEOUT.
- err_proto  out  1  sticky; mul_out_valid outside WAIT.

Function
REQ-005 SHALL accept a pair when op_valid && op_ready on a clock edge.
REQ-006 SHALL drive op_ready = (level < DEPTH), combinationally from registered state.
REQ-007 SHALL, when full, ignore op_valid, leaving FIFO contents unchanged and raising no error.
REQ-008 SHALL use wrap-around read and write pointers modulo DEPTH.
REQ-009 SHALL, on simultaneous push and pop, leave level unchanged; push when full remains illegal even if a pop occurs in the same cycle.
REQ-010 SHALL implement FSM states IDLE, ISSUE and WAIT, with IDLE as the reset state.
REQ-011 SHALL transition IDLE -> ISSUE when level != 0; pairs pushed this cycle are not visible until next cycle.
REQ-012 SHALL, in ISSUE, drive mul_in_valid=1 for exactly one cycle with the FIFO head on mul_a/mul_b, pop the head, and go to WAIT.
REQ-013 SHALL drive mul_in_valid low in IDLE and WAIT, and hold mul_a/mul_b at their last issued values.
REQ-014 SHALL, in WAIT, on mul_out_valid=1 register mul_o into res_data, pulse res_valid the next cycle, and return to IDLE.
REQ-015 SHALL accept the next ISSUE no earlier than the cycle after IDLE is re-entered, since the multiplier clears busy one cycle after its finish pulse.
REQ-016 SHALL increment an issue counter, modulo DEPTH, on each ISSUE; res_tag equals the counter value at the issue of that result.
REQ-017 SHALL count WAIT cycles; when the count reaches TIMEOUT without mul_out_valid, set err_timeout, return to IDLE, and produce no res_valid.
REQ-018 SHALL, if mul_out_valid=1 in IDLE or ISSUE, set err_proto and otherwise ignore it, with no capture.
REQ-019 SHALL pass a==0 or b==0 through unchanged; the product 0 is still issued and reported.
REQ-020 SHALL bound throughput at one operation per multiplier latency plus 2 cycles.

Reset
REQ-021 SHALL, while rst=1, empty the FIFO (level=0, pointers=0) and enter IDLE.
REQ-022 SHALL, while rst=1, clear the issue counter, err_timeout and err_proto.
REQ-023 SHALL, while rst=1, hold res_valid=0, res_data=0, res_tag=0, mul_in_valid=0, mul_a=0 and mul_b=0.
REQ-024 SHALL reset mid-WAIT by abandoning the outstanding operation without a result.
REQ-025 SHALL give rst priority over every simultaneous push, issue or capture.
REQ-026 SHALL drive op_ready=1 on the first cycle after rst deasserts.

Verification
REQ-027 SHALL cover push a=3,b=2 -> one mul_in_valid pulse with mul_a=3,mul_b=2 -> res_valid with res_data=6, res_tag=0.
REQ-028 SHALL cover pushing 5 pairs back-to-back with no multiplier finish -> op_ready=0 after the 4th, level=4, and the 5th not stored.
REQ-029 SHALL cover pairs (3,3),(2,1),(0,3),(1,0) -> results 9,2,0,0 with tags 0,1,2,3, in order, at most one outstanding issue.
REQ-030 SHALL cover issue then hold mul_out_valid=0 -> err_timeout=1 exactly TIMEOUT=8 cycles after the ISSUE cycle, no res_valid, and the next pair issued.
REQ-031 SHALL cover mul_out_valid=1 while IDLE with an empty FIFO -> err_proto=1 and no res_valid.
REQ-032 SHALL cover rst=1 during WAIT with 2 queued pairs -> level=0, res_valid=0, no later mul_in_valid until a new push.
